alu_operand_stage: RTL

Registered operand stage that sits directly upstream of the ALU datapath. Each cycle it accepts an x operand, two candidate y operands (A register and memory word) with a select bit, and the six ALU control bits. It resolves the y selection, and presents the captured operand set to the ALU over a valid/ready handshake. A two-entry skid buffer decouples the fetch/decode side from ALU back-pressure without losing or reordering operand sets.

---
 rtl/alu_operand_stage_if.sv | 42 ++++
 rtl/alu_operand_stage.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage_if.sv
// ---------------------------------------------------------------------------
// alu_operand_stage_if
// Groups the operand-stage handshake signals. The upstream side carries one
// x operand, two candidate y operands with a select bit and the ALU control
// bundle. The downstream side carries the resolved operand set to the ALU.
//
//   in_valid / in_ready        upstream valid/ready handshake
//   x, y_a, y_m, sel_m, ctrl   upstream operand set
//   out_valid / out_ready      downstream valid/ready handshake
//   out_x, out_y, out_ctrl     registered operand set presented to the ALU
//
// Modports:
//   slave  - the operand stage itself
//   master - the environment that feeds it and consumes its output
// ---------------------------------------------------------------------------
interface alu_operand_stage_if #(
    parameter int WIDTH  = 16,
    parameter int CTRL_W = 6
);
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  x;
    logic [WIDTH-1:0]  y_a;
    logic [WIDTH-1:0]  y_m;
    logic              sel_m;
    logic [CTRL_W-1:0] ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_x;
    logic [WIDTH-1:0]  out_y;
    logic [CTRL_W-1:0] out_ctrl;

    modport slave (
        input  in_valid, x, y_a, y_m, sel_m, ctrl, out_ready,
        output in_ready, out_valid, out_x, out_y, out_ctrl
    );

    modport master (
        output in_valid, x, y_a, y_m, sel_m, ctrl, out_ready,
        input  in_ready, out_valid, out_x, out_y, out_ctrl
    );
endinterface

// File: rtl/alu_operand_stage.sv
// ---------------------------------------------------------------------------
// alu_operand_stage
// Registered operand stage in front of the ALU. Each accepted set has its y
// operand resolved (sel_m ? y_m : y_a) at acceptance, so only the selected
// value is stored. A main entry drives the outputs and a skid entry absorbs
// one extra set when the ALU stalls, so in_ready and out_valid can both be
// decoded purely from the state register.
//
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous, active-high reset
//   bus  - alu_operand_stage_if.slave (handshakes and operand data)
//
// Parameters:
//   WIDTH  - operand width
//   CTRL_W - ALU control width, {zx, nx, zy, ny, f, no} MSB to LSB
// ---------------------------------------------------------------------------
module alu_operand_stage #(
    parameter int WIDTH  = 16,
    parameter int CTRL_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_operand_stage_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [WIDTH-1:0]  main_x_reg;
    logic [WIDTH-1:0]  main_y_reg;
    logic [CTRL_W-1:0] main_ctrl_reg;
    logic [WIDTH-1:0]  skid_x_reg;
    logic [WIDTH-1:0]  skid_y_reg;
    logic [CTRL_W-1:0] skid_ctrl_reg;

    logic             in_ready_int;
    logic             out_valid_int;
    logic             in_fire;
    logic             out_fire;
    logic [WIDTH-1:0] y_sel;

    // Load strobes decoded alongside the outputs.
    logic load_main_from_in;
    logic load_main_from_skid;
    logic load_skid;

    assign in_fire  = bus.in_valid & in_ready_int;
    assign out_fire = out_valid_int & bus.out_ready;
    assign y_sel    = bus.sel_m ? bus.y_m : bus.y_a;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_EMPTY: begin
                if (in_fire) state_next = ST_ONE;
            end
            ST_ONE: begin
                if (in_fire && !out_fire)      state_next = ST_FULL;
                else if (!in_fire && out_fire) state_next = ST_EMPTY;
            end
            ST_FULL: begin
                if (out_fire) state_next = ST_ONE;
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    // ---------------- output / strobe decode ----------------
    always_comb begin
        in_ready_int        = 1'b0;
        out_valid_int       = 1'b0;
        load_main_from_in   = 1'b0;
        load_main_from_skid = 1'b0;
        load_skid           = 1'b0;
        case (state_reg)
            ST_EMPTY: begin
                in_ready_int      = 1'b1;
                load_main_from_in = bus.in_valid;
            end
            ST_ONE: begin
                in_ready_int      = 1'b1;
                out_valid_int     = 1'b1;
                // Simultaneous fire replaces main directly; never via EMPTY.
                load_main_from_in = bus.in_valid & bus.out_ready;
                load_skid         = bus.in_valid & ~bus.out_ready;
            end
            ST_FULL: begin
                out_valid_int       = 1'b1;
                load_main_from_skid = bus.out_ready;
            end
            default: begin
                in_ready_int  = 1'b0;
                out_valid_int = 1'b0;
            end
        endcase
    end

    // ---------------- data storage ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            main_x_reg    <= '0;
            main_y_reg    <= '0;
            main_ctrl_reg <= '0;
            skid_x_reg    <= '0;
            skid_y_reg    <= '0;
            skid_ctrl_reg <= '0;
        end else begin
            if (load_main_from_in) begin
                main_x_reg    <= bus.x;
                main_y_reg    <= y_sel;
                main_ctrl_reg <= bus.ctrl;
            end else if (load_main_from_skid) begin
                main_x_reg    <= skid_x_reg;
                main_y_reg    <= skid_y_reg;
                main_ctrl_reg <= skid_ctrl_reg;
            end
            if (load_skid) begin
                skid_x_reg    <= bus.x;
                skid_y_reg    <= y_sel;
                skid_ctrl_reg <= bus.ctrl;
            end
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_int;
    assign bus.out_x     = main_x_reg;
    assign bus.out_y     = main_y_reg;
    assign bus.out_ctrl  = main_ctrl_reg;

endmodule
